// File: rtl/demo_de0_sys_nios2_qsys_0_oci_dct_ctrl.sv
// Trace-capture sequencer: packs 2-bit trace atoms into 30-bit words, hands them to a
// valid/ready sink and flushes a partial word at end of test. Optional DCT_DROP_COUNT_EN adds drop_count.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | accepting atoms, emitting full words
// S_FLUSH | atoms ignored, draining partial accumulator and pending word
// S_ENDED | flush complete, test_has_ended held until reset
module demo_de0_sys_nios2_qsys_0_oci_dct_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        atom_valid,
  input  logic [1:0]  atom_data,
  input  logic        test_ending,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [29:0] out_buffer,
  output logic [3:0]  out_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  output logic        test_has_ended
`ifdef DCT_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_ENDED} state_t;

  state_t state;

  logic slot_free;
  logic acc_full;
  logic transfer;
  logic take;
  logic drop;

  assign slot_free = !out_valid || out_ready;
  assign acc_full  = (dct_count == 4'd15);
  assign transfer  = slot_free && (acc_full || ((state == S_FLUSH) && (dct_count != 4'd0)));
  assign take      = atom_valid && (state == S_RUN);
  // The CPU cannot be stalled, so a full accumulator behind a blocked sink loses the atom.
  assign drop      = take && acc_full && !slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_RUN;
      out_valid      <= 1'b0;
      out_buffer     <= 30'd0;
      out_count      <= 4'd0;
      dct_buffer     <= 30'd0;
      dct_count      <= 4'd0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
`ifdef DCT_DROP_COUNT_EN
      drop_count     <= 16'd0;
`endif
    end else begin
      if (transfer) begin
        out_buffer <= dct_buffer;
        out_count  <= dct_count;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // An atom arriving with a transfer starts the freshly cleared accumulator.
      if (take && !drop) begin
        if (transfer) begin
          dct_buffer <= {28'd0, atom_data};
          dct_count  <= 4'd1;
        end else begin
          dct_buffer[{dct_count, 1'b0} +: 2] <= atom_data;
          dct_count <= dct_count + 4'd1;
        end
      end else if (transfer) begin
        dct_buffer <= 30'd0;
        dct_count  <= 4'd0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end
`ifdef DCT_DROP_COUNT_EN
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
`endif

      case (state)
        S_RUN: begin
          if (test_ending) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if ((dct_count == 4'd0) && !out_valid) begin
            state          <= S_ENDED;
            test_has_ended <= 1'b1;
          end
        end
        S_ENDED: begin
          state <= S_ENDED;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demo_de0_sys_nios2_qsys_0_oci_dct_ctrl.sv
// Self-checking bench for the trace-capture sequencer: directed scenarios plus a
// randomized run against a queue-based model of the atom stream.
module tb_demo_de0_sys_nios2_qsys_0_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        test_ending = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [29:0] out_buffer;
  logic [3:0]  out_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        test_has_ended;
`ifdef DCT_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int failures = 0;

  demo_de0_sys_nios2_qsys_0_oci_dct_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .test_ending    (test_ending),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_buffer     (out_buffer),
    .out_count      (out_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .test_has_ended (test_has_ended)
`ifdef DCT_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: accumulator and output word as atom queues; mode 0 run, 1 flush, 2 ended.
  logic [1:0]  m_acc[$];
  logic [1:0]  m_out[$];
  bit          m_ov = 0;
  int          m_mode = 0;
  bit          m_ovf = 0;
  bit          m_end = 0;
  int          m_drops = 0;
  logic [29:0] m_dct_buf = 30'd0;
  logic [29:0] m_out_buf = 30'd0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_acc.delete();
        m_out.delete();
        m_ov = 0; m_mode = 0; m_ovf = 0; m_end = 0; m_drops = 0;
      end else begin
        int n0;
        bit ov0, sf, xf;
        n0  = m_acc.size();
        ov0 = m_ov;
        sf  = !ov0 || out_ready;
        xf  = sf && (n0 == 15 || (m_mode == 1 && n0 != 0));
        if (xf) begin
          m_out = m_acc;
          m_acc.delete();
          m_ov = 1;
        end else if (ov0 && out_ready) begin
          m_ov = 0;
        end
        if (atom_valid && m_mode == 0) begin
          if (m_acc.size() < 15) m_acc.push_back(atom_data);
          else begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
          end
        end
        if (m_mode == 0 && test_ending) m_mode = 1;
        else if (m_mode == 1 && n0 == 0 && !ov0) begin
          m_mode = 2;
          m_end = 1;
        end
      end
      m_dct_buf = 30'd0;
      for (int i = 0; i < m_acc.size(); i++) m_dct_buf = m_dct_buf + (30'(m_acc[i]) << (2 * i));
      m_out_buf = 30'd0;
      for (int i = 0; i < m_out.size(); i++) m_out_buf = m_out_buf + (30'(m_out[i]) << (2 * i));
    end
  end

  task automatic drive(input bit av, input bit [1:0] ad, input bit te, input bit rdy);
    atom_valid  = av;
    atom_data   = ad;
    test_ending = te;
    out_ready   = rdy;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(0, 2'd0, 0, 1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 2'd3, 0, 1);
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0h exp 0", out_valid); end
    checks++; if (out_buffer !== 30'd0) begin failures++; $display("FAIL reset_out_buffer: got %h exp 0", out_buffer); end
    checks++; if (out_count !== 4'd0) begin failures++; $display("FAIL reset_out_count: got %0d exp 0", out_count); end
    checks++; if (dct_buffer !== 30'd0) begin failures++; $display("FAIL reset_dct_buffer: got %h exp 0", dct_buffer); end
    checks++; if (dct_count !== 4'd0) begin failures++; $display("FAIL reset_dct_count: got %0d exp 0", dct_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0h exp 0", overflow); end
    checks++; if (test_has_ended !== 1'b0) begin failures++; $display("FAIL reset_ended: got %0h exp 0", test_has_ended); end
`ifdef DCT_DROP_COUNT_EN
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count: got %0d exp 0", drop_count); end
`endif
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < 15; i++) drive(1, 2'b01, 0, 1);
    checks++; if (dct_count !== 4'd15) begin failures++; $display("FAIL fill_count15: got %0d exp 15", dct_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_early_valid: got %0h exp 0", out_valid); end
    drive(0, 2'd0, 0, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_valid: got %0h exp 1", out_valid); end
    checks++; if (out_buffer !== 30'h15555555) begin failures++; $display("FAIL fill_buffer: got %h exp 15555555", out_buffer); end
    checks++; if (out_count !== 4'd15) begin failures++; $display("FAIL fill_out_count: got %0d exp 15", out_count); end
    checks++; if (dct_count !== 4'd0) begin failures++; $display("FAIL fill_dct_cleared: got %0d exp 0", dct_count); end
    drive(0, 2'd0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_valid_drop: got %0h exp 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow: got %0h exp 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp_w [2];
    logic [29:0] got_w [$];
    logic [3:0]  got_c [$];
    exp_w[0] = 30'd0;
    exp_w[1] = 30'd0;
    for (int i = 0; i < 30; i++) exp_w[i / 15] = exp_w[i / 15] | (30'(i % 4) << (2 * (i % 15)));
    apply_reset();
    for (int i = 0; i < 34; i++) begin
      if (i < 30) drive(1, 2'(i % 4), 0, 1);
      else drive(0, 2'd0, 0, 1);
      if (out_valid) begin
        got_w.push_back(out_buffer);
        got_c.push_back(out_count);
      end
    end
    checks++; if (got_w.size() != 2) begin failures++; $display("FAIL b2b_words: got %0d exp 2", got_w.size()); end
    for (int k = 0; k < got_w.size() && k < 2; k++) begin
      checks++; if (got_w[k] !== exp_w[k]) begin failures++; $display("FAIL b2b_word%0d: got %h exp %h", k, got_w[k], exp_w[k]); end
      checks++; if (got_c[k] !== 4'd15) begin failures++; $display("FAIL b2b_count%0d: got %0d exp 15", k, got_c[k]); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow: got %0h exp 0", overflow); end
  endtask

  task automatic test_backpressure();
    logic [1:0]  a [32];
    logic [29:0] w0, w1, held;
    bit          seen;
    w0 = 30'd0; w1 = 30'd0; seen = 0; held = 30'd0;
    for (int i = 0; i < 32; i++) a[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 15; i++) begin
      w0 = w0 | (30'(a[i]) << (2 * i));
      w1 = w1 | (30'(a[i + 15]) << (2 * i));
    end
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, a[i], 0, 0);
      if (out_valid) begin
        if (!seen) begin held = out_buffer; seen = 1; end
        checks++; if (out_buffer !== held) begin failures++; $display("FAIL bp_stable: got %h exp %h", out_buffer, held); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %0h exp 1", out_valid); end
    checks++; if (out_buffer !== w0) begin failures++; $display("FAIL bp_word0: got %h exp %h", out_buffer, w0); end
    checks++; if (dct_count !== 4'd15) begin failures++; $display("FAIL bp_acc_count: got %0d exp 15", dct_count); end
    checks++; if (dct_buffer !== w1) begin failures++; $display("FAIL bp_acc_buf: got %h exp %h", dct_buffer, w1); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %0h exp 1", overflow); end
`ifdef DCT_DROP_COUNT_EN
    checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL bp_drop_count: got %0d exp 2", drop_count); end
`endif
    drive(0, 2'd0, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_buffer !== w1) begin failures++; $display("FAIL bp_word1: got v=%0h %h exp v=1 %h", out_valid, out_buffer, w1); end
    checks++; if (dct_count !== 4'd0) begin failures++; $display("FAIL bp_acc_drained: got %0d exp 0", dct_count); end
    drive(0, 2'd0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_done: got %0h exp 0", out_valid); end
  endtask

  task automatic test_partial_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1, 2'b11, 0, 1);
    drive(0, 2'd0, 1, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pf_t0_valid: got %0h exp 0", out_valid); end
    drive(1, 2'b10, 1, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pf_valid: got %0h exp 1", out_valid); end
    checks++; if (out_count !== 4'd3) begin failures++; $display("FAIL pf_count: got %0d exp 3", out_count); end
    checks++; if (out_buffer !== 30'h3F) begin failures++; $display("FAIL pf_buffer: got %h exp 3f", out_buffer); end
    checks++; if (dct_count !== 4'd0) begin failures++; $display("FAIL pf_atom_ignored: got %0d exp 0", dct_count); end
    drive(1, 2'b10, 0, 1);
    checks++; if (out_valid !== 1'b0 || test_has_ended !== 1'b0) begin failures++; $display("FAIL pf_t3: got v=%0h e=%0h exp v=0 e=0", out_valid, test_has_ended); end
    drive(1, 2'b01, 0, 1);
    checks++; if (test_has_ended !== 1'b1) begin failures++; $display("FAIL pf_ended: got %0h exp 1", test_has_ended); end
    for (int i = 0; i < 4; i++) drive(1, 2'b01, 0, 1);
    checks++; if (dct_count !== 4'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL pf_after: got c=%0d v=%0h exp c=0 v=0", dct_count, out_valid); end
  endtask

  task automatic test_empty_flush();
    apply_reset();
    drive(0, 2'd0, 1, 1);
    checks++; if (test_has_ended !== 1'b0) begin failures++; $display("FAIL ef_early: got %0h exp 0", test_has_ended); end
    drive(0, 2'd0, 1, 1);
    checks++; if (test_has_ended !== 1'b1) begin failures++; $display("FAIL ef_ended: got %0h exp 1", test_has_ended); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ef_no_word: got %0h exp 0", out_valid); end
    for (int i = 0; i < 3; i++) drive(1, 2'd2, 0, 1);
    checks++; if (test_has_ended !== 1'b1 || dct_count !== 4'd0) begin failures++; $display("FAIL ef_held: got e=%0h c=%0d exp e=1 c=0", test_has_ended, dct_count); end
  endtask

  task automatic test_reset_mid_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(1, 2'd1, 0, 0);
    drive(0, 2'd0, 1, 0);
    drive(0, 2'd0, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_count !== 4'd5) begin failures++; $display("FAIL rmf_pending: got v=%0h c=%0d exp v=1 c=5", out_valid, out_count); end
    reset = 1'b1;
    drive(0, 2'd0, 1, 0);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_buffer !== 30'd0 || out_count !== 4'd0) begin failures++; $display("FAIL rmf_out: got v=%0h %h c=%0d exp 0", out_valid, out_buffer, out_count); end
    checks++; if (dct_buffer !== 30'd0 || dct_count !== 4'd0 || overflow !== 1'b0 || test_has_ended !== 1'b0) begin failures++; $display("FAIL rmf_state: got %h c=%0d o=%0h e=%0h exp 0", dct_buffer, dct_count, overflow, test_has_ended); end
    drive(1, 2'd2, 0, 1);
    checks++; if (dct_count !== 4'd1 || dct_buffer !== 30'd2) begin failures++; $display("FAIL rmf_run: got c=%0d %h exp c=1 2", dct_count, dct_buffer); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), c >= 440, $urandom_range(0, 9) < 4);
      checks++; if (out_valid !== m_ov) begin failures++; $display("FAIL rnd_out_valid c%0d: got %0h exp %0h", c, out_valid, m_ov); end
      checks++; if (out_buffer !== m_out_buf) begin failures++; $display("FAIL rnd_out_buffer c%0d: got %h exp %h", c, out_buffer, m_out_buf); end
      checks++; if (out_count !== 4'(m_out.size())) begin failures++; $display("FAIL rnd_out_count c%0d: got %0d exp %0d", c, out_count, m_out.size()); end
      checks++; if (dct_buffer !== m_dct_buf) begin failures++; $display("FAIL rnd_dct_buffer c%0d: got %h exp %h", c, dct_buffer, m_dct_buf); end
      checks++; if (dct_count !== 4'(m_acc.size())) begin failures++; $display("FAIL rnd_dct_count c%0d: got %0d exp %0d", c, dct_count, m_acc.size()); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow c%0d: got %0h exp %0h", c, overflow, m_ovf); end
      checks++; if (test_has_ended !== m_end) begin failures++; $display("FAIL rnd_ended c%0d: got %0h exp %0h", c, test_has_ended, m_end); end
`ifdef DCT_DROP_COUNT_EN
      checks++; if (drop_count !== 16'(m_drops)) begin failures++; $display("FAIL rnd_drop_count c%0d: got %0d exp %0d", c, drop_count, m_drops); end
`endif
    end
    checks++; if (m_end != 1 || test_has_ended !== 1'b1) begin failures++; $display("FAIL rnd_final_ended: got %0h exp 1", test_has_ended); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_partial_flush();
    test_empty_flush();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
